feed_msg_assembler: RTL and testbench
=====================================

Name: feed_msg_assembler

Overview:
- Producer side of the 320-bit feed-message interface that the parser/order-book cluster consumes (ff_buffer, buffer_not_empty, system_free).
- Accepts a network byte stream with start-of-message marking and assembles fixed 40-byte messages.
- Queues completed messages in a small FIFO and presents the head entry until the order-book cluster reports system_free.

Parameters:
- DEPTH, 4, number of completed-message FIFO entries; power of 2, minimum 2.
- MSG_BYTES, 40, bytes per message; ff_buffer width = MSG_BYTES*8 = 320.

Ports:
- clk  in  1  single clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data/in_sop valid this cycle.
- in_data  in  8  stream byte.
- in_sop  in  1  byte is first byte of a message.
- in_ready  out  1  assembler accepts a byte this cycle (accept = in_valid && in_ready).
- ff_buffer  out  MSG_BYTES*8  head-of-FIFO message; first received byte in bits [319:312], last byte in [7:0].
- buffer_not_empty  out  1  FIFO holds at least one complete message.
- system_free  in  1  consumer ready; pop = buffer_not_empty && system_free at a rising edge.
- fifo_level  out  $clog2(DEPTH)+1  number of stored messages, 0..DEPTH.

Behaviour:
- Reset (async assert, sync release): state=IDLE, byte_cnt=0, FIFO empty, fifo_level=0, buffer_not_empty=0, ff_buffer=0, assembly register=0. Reset mid-message discards the partial message and all queued messages.
- FSM IDLE: accepted byte with in_sop=1 is written to bits [319:312], byte_cnt=1, go to ASSEMBLE. Accepted byte with in_sop=0 is dropped; stay in IDLE.
- FSM ASSEMBLE: accepted byte with in_sop=0 is written to slot byte_cnt, and byte_cnt increments.
  - On the byte with byte_cnt==MSG_BYTES-1, the full message (including that byte) is pushed to the FIFO in the same edge; byte_cnt=0; go to IDLE.
  - Accepted byte with in_sop=1 in ASSEMBLE: partial message discarded and counted as a drop; the byte starts a new message (byte_cnt=1, stay in ASSEMBLE).
- in_ready: combinational = !(state==ASSEMBLE && byte_cnt==MSG_BYTES-1 && fifo full). It does not depend on system_free, so there is no combinational path from consumer to producer. Bytes 0..38 are always accepted, even when the FIFO is full.
- Push/pop timing:
  - Push latency: message visible on ff_buffer / buffer_not_empty the cycle after its last byte is accepted, if the FIFO was empty.
  - Pop: head advances at the edge where pop is true. The next entry (or ff_buffer hold, with buffer_not_empty=0 when empty) is visible the following cycle.
- Simultaneous push and pop:
  - Both occur; fifo_level unchanged.
  - When full, push is impossible by in_ready rule, even if pop in the same cycle (conservative).
  - When empty, pop is impossible since buffer_not_empty=0.
- ff_buffer is driven from registered FIFO storage (read pointer index), glitch-free. When empty it holds the last popped value (don't-care to consumer).
- Pointers: read and write pointers, $clog2(DEPTH) bits, wrap naturally; full/empty derived from fifo_level.
- buffer_not_empty = (fifo_level != 0), registered-equivalent (derived from registered level).

Optional Feature:
- Macro: FEED_DROP_CNT_EN.
- With the macro: extra output port drop_count out 16, reset 0.
  - Increments by 1 for each byte dropped in IDLE (in_sop=0) and for each partial message aborted by in_sop in ASSEMBLE. An abort counts once, not per byte.
  - Saturates at 16'hFFFF.
  - Both events cannot occur in one cycle.
- Without the macro: port and counter absent; drops are silent; all other behaviour identical.

Test Plan:
- Single message: in_sop on byte 0x00, then bytes 0x01..0x27 back-to-back, system_free=0 → buffer_not_empty=1 one cycle after byte 0x27; ff_buffer[319:312]=8'h00, ff_buffer[7:0]=8'h27; fifo_level=1.
- Fill/backpressure: 5 messages with system_free=0, DEPTH=4 → fifo_level=4; in_ready=0 when 5th message reaches byte 39. Raise system_free for 1 cycle → fifo_level=3, in_ready=1, 5th message pushes, level=4.
- Simultaneous push/pop: level=2, last byte accepted in the same cycle as system_free=1 → level stays 2; head advances to the 2nd message; ordering preserved (first bytes 0xA0,0xA1,0xA2 popped in order).
- Abort: in_sop + 10 bytes, then in_sop 0x55 + 39 bytes → exactly one message queued with ff_buffer[319:312]=8'h55. drop_count=1 with FEED_DROP_CNT_EN.
- Stray bytes: 3 bytes in IDLE with in_sop=0 → nothing queued, in_ready=1 throughout; drop_count=3 with FEED_DROP_CNT_EN.
- Reset mid-operation: level=2 and byte 20 of a message in progress, pulse resetn low asynchronously → immediately buffer_not_empty=0, fifo_level=0. After release, a new complete message is assembled correctly from byte slot 0.

Source files
------------

// File: rtl/feed_msg_assembler.sv
// Assembles a start-of-message-marked byte stream into fixed MSG_BYTES messages, queued for the order-book cluster.
// Latency: a message is on ff_buffer / buffer_not_empty one cycle after its last byte is accepted (FIFO empty).
// Backpressure: in_ready drops only on the final byte of a message while the FIFO is full. Optional FEED_DROP_CNT_EN adds drop_count.

module feed_msg_fifo #(
    parameter int WIDTH = 320,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] head_idx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // When empty, point one slot back so the last popped message stays on the output.
    assign head_idx = (level == '0) ? (rd_ptr - 1'b1) : rd_ptr;
    assign head_dat = mem[head_idx];

endmodule

module feed_msg_assembler #(
    parameter int DEPTH     = 4,
    parameter int MSG_BYTES = 40
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     in_sop,
    output logic                     in_ready,
    output logic [MSG_BYTES*8-1:0]   ff_buffer,
    output logic                     buffer_not_empty,
    input  logic                     system_free,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef FEED_DROP_CNT_EN
    ,
    output logic [15:0]              drop_count
`endif
);
    localparam int W     = MSG_BYTES * 8;
    localparam int CNT_W = $clog2(MSG_BYTES);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MSG_BYTES - 1);

    typedef enum logic {
        IDLE,
        ASSEMBLE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] byte_cnt;
    logic [W-1:0]     asm_q;
    logic [W-1:0]     push_dat;
    logic             last_slot;
    logic             fifo_full;
    logic             accept;
    logic             push;
    logic             pop;

    assign last_slot = (state == ASSEMBLE) && (byte_cnt == LAST_IDX);
    assign fifo_full = (fifo_level == LVL_W'(DEPTH));

    // Deliberately blind to system_free: no combinational path from consumer to producer.
    assign in_ready = !(last_slot && fifo_full);
    assign accept   = in_valid && in_ready;
    assign push     = accept && last_slot && !in_sop;
    assign pop      = buffer_not_empty && system_free;
    assign push_dat = {asm_q[W-1:8], in_data};

    assign buffer_not_empty = (fifo_level != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            byte_cnt <= '0;
            asm_q    <= '0;
        end else if (accept) begin
            if (in_sop) begin
                // Starts a message from IDLE, or aborts a partial one and restarts.
                asm_q[W-1 -: 8] <= in_data;
                byte_cnt        <= CNT_W'(1);
                state           <= ASSEMBLE;
            end else if (state == ASSEMBLE) begin
                if (last_slot) begin
                    byte_cnt <= '0;
                    state    <= IDLE;
                end else begin
                    for (int i = 1; i < MSG_BYTES - 1; i++) begin
                        if (byte_cnt == CNT_W'(i)) begin
                            asm_q[(MSG_BYTES-1-i)*8 +: 8] <= in_data;
                        end
                    end
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

    feed_msg_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (ff_buffer),
        .level    (fifo_level)
    );

`ifdef FEED_DROP_CNT_EN
    logic drop_ev;

    // Stray byte in IDLE, or an abort (counted once, on the restarting sop byte).
    assign drop_ev = accept && (in_sop ? (state == ASSEMBLE) : (state == IDLE));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_count <= '0;
        end else if (drop_ev && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_feed_msg_assembler.sv
// Scoreboard bench for feed_msg_assembler: stimulus queues expected messages, a monitor checks each pop.
module tb_feed_msg_assembler;
    localparam int DEPTH = 4;
    localparam int MB    = 40;
    localparam int W     = MB * 8;

    logic                   clk;
    logic                   resetn;
    logic                   in_valid;
    logic [7:0]             in_data;
    logic                   in_sop;
    logic                   in_ready;
    logic [W-1:0]           ff_buffer;
    logic                   buffer_not_empty;
    logic                   system_free;
    logic [$clog2(DEPTH):0] fifo_level;
`ifdef FEED_DROP_CNT_EN
    logic [15:0]            drop_count;
`endif

    feed_msg_assembler #(.DEPTH(DEPTH), .MSG_BYTES(MB)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_sop           (in_sop),
        .in_ready         (in_ready),
        .ff_buffer        (ff_buffer),
        .buffer_not_empty (buffer_not_empty),
        .system_free      (system_free),
        .fifo_level       (fifo_level)
`ifdef FEED_DROP_CNT_EN
        ,
        .drop_count       (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_drops = 0;
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] make_msg(input logic [7:0] base);
        logic [W-1:0] m;
        m = '0;
        for (int i = 0; i < MB; i++) begin
            m[(MB-1-i)*8 +: 8] = base + 8'(i);
        end
        return m;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT pops, the head must match the oldest expected message.
    always @(negedge clk) begin
        if (resetn && buffer_not_empty && system_free) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got %0h expected no message", ff_buffer);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (ff_buffer !== e) begin
                    n_fail++;
                    $display("FAIL pop_data: got %0h expected %0h", ff_buffer, e);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the byte.
    task automatic send_byte(input logic [7:0] d, input logic sop);
        int waitc;
        waitc = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = sop;
        @(negedge clk);
        while (!in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic send_partial(input logic [7:0] base, input int n);
        send_byte(base, 1'b1);
        for (int i = 1; i < n; i++) begin
            send_byte(base + 8'(i), 1'b0);
        end
    endtask

    task automatic send_msg(input logic [7:0] base);
        send_partial(base, MB);
        exp_q.push_back(make_msg(base));
    endtask

    task automatic drain();
        system_free = 1'b1;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            @(negedge clk);
            if (!buffer_not_empty) break;
        end
        @(posedge clk);
        #1;
        system_free = 1'b0;
        @(negedge clk);
        check("drain_level", W'(fifo_level), W'(0));
        check("drain_bne", W'(buffer_not_empty), W'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic check_drops(input string name);
`ifdef FEED_DROP_CNT_EN
        check(name, W'(drop_count), W'(exp_drops));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        in_sop = 1'b0;
        system_free = 1'b0;
        #12;
        check("rst_level", W'(fifo_level), W'(0));
        check("rst_bne", W'(buffer_not_empty), W'(0));
        check("rst_ff_buffer", ff_buffer, W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));
        check_drops("rst_drops");
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Single message 0x00..0x27
        send_msg(8'h00);
        @(negedge clk);
        check("single_bne", W'(buffer_not_empty), W'(1));
        check("single_first", W'(ff_buffer[319:312]), W'(8'h00));
        check("single_last", W'(ff_buffer[7:0]), W'(8'h27));
        check("single_level", W'(fifo_level), W'(1));
        @(posedge clk);
        #1;
        drain();

        // Fill to DEPTH, then backpressure on the fifth message's final byte
        send_msg(8'h10);
        send_msg(8'h20);
        send_msg(8'h30);
        send_msg(8'h40);
        @(negedge clk);
        check("fill_level", W'(fifo_level), W'(4));
        @(posedge clk);
        #1;
        send_partial(8'h50, MB - 1);
        in_valid = 1'b1;
        in_data  = 8'h50 + 8'd39;
        in_sop   = 1'b0;
        @(negedge clk);
        check("bp_in_ready", W'(in_ready), W'(0));
        check("bp_level", W'(fifo_level), W'(4));
        @(posedge clk);
        #1;
        system_free = 1'b1;
        @(posedge clk);
        #1;
        system_free = 1'b0;
        @(negedge clk);
        check("bp_level_after_pop", W'(fifo_level), W'(3));
        check("bp_in_ready_after_pop", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(make_msg(8'h50));
        @(negedge clk);
        check("bp_level_refill", W'(fifo_level), W'(4));
        @(posedge clk);
        #1;
        drain();

        // Simultaneous push and pop at level 2
        send_msg(8'hA0);
        send_msg(8'hA1);
        send_partial(8'hA2, MB - 1);
        system_free = 1'b1;
        send_byte(8'hA2 + 8'd39, 1'b0);
        system_free = 1'b0;
        exp_q.push_back(make_msg(8'hA2));
        @(negedge clk);
        check("pp_level", W'(fifo_level), W'(2));
        check("pp_head", W'(ff_buffer[319:312]), W'(8'hA1));
        @(posedge clk);
        #1;
        drain();

        // Abort: partial message restarted by a new sop
        send_partial(8'h11, 11);
        send_msg(8'h55);
        exp_drops = exp_drops + 1;
        @(negedge clk);
        check("abort_level", W'(fifo_level), W'(1));
        check("abort_head", W'(ff_buffer[319:312]), W'(8'h55));
        check_drops("abort_drops");
        @(posedge clk);
        #1;
        drain();

        // Stray bytes in IDLE
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hE0 + 8'(i), 1'b0);
            check("stray_in_ready", W'(in_ready), W'(1));
            check("stray_bne", W'(buffer_not_empty), W'(0));
        end
        exp_drops = exp_drops + 3;
        check_drops("stray_drops");

        // Reset mid-operation
        send_msg(8'hB0);
        send_msg(8'hB1);
        send_partial(8'hB2, 20);
        #2;
        resetn = 1'b0;
        #1;
        exp_q.delete();
        exp_drops = 0;
        check("arst_bne", W'(buffer_not_empty), W'(0));
        check("arst_level", W'(fifo_level), W'(0));
        check("arst_ff_buffer", ff_buffer, W'(0));
        check_drops("arst_drops");
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        send_msg(8'hC0);
        @(negedge clk);
        check("post_rst_level", W'(fifo_level), W'(1));
        check("post_rst_msg", ff_buffer, make_msg(8'hC0));
        @(posedge clk);
        #1;
        drain();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
